pkt_gap_inserter: RTL

PKT_GAP_INSERTER -- requirements
Module: pkt_gap_inserter

---
 rtl/pkt_gap_inserter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pkt_gap_inserter.sv
// Purpose : inserts a programmable idle gap ahead of each packet's first beat on an AXI4-Stream path.
// Latency : zero; data/tuser/tstrb/tlast pass through combinationally, only valid/ready are gated.
// Backpr. : while the gap runs both tvalid (down) and tready (up) are held low; otherwise ready follows m_axis_tready.
//
// Ports:
//   axi_aclk, axi_rst      clock, synchronous active-high reset
//   s_axis_*               upstream packet stream
//   m_axis_*               gated stream towards the rate limiter
//   sw_rst                 software reset, same effect as axi_rst
//   gap_en                 enables gap insertion
//   use_reg_gap            1: gap length from gap_value, 0: from first-beat s_axis_tuser[63:32]
//   gap_value              register gap length in clock cycles
//   pkt_cnt                packets forwarded (wrapping)
//   stall_cnt              cycles a presented beat was held by the gap (saturating)
module pkt_gap_inserter #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32
) (
  input  logic                                axi_aclk,
  input  logic                                axi_rst,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic                                s_axis_tvalid,
  input  logic                                s_axis_tlast,
  output logic                                s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,
  input  logic                                sw_rst,
  input  logic                                gap_en,
  input  logic                                use_reg_gap,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       gap_value,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       pkt_cnt,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       stall_cnt
);

  typedef enum logic [1:0] {IDLE, GAP, PKT} state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] d;
  logic        rst_any;
  logic        gate;
  logic        xfer;

  assign rst_any = axi_rst | sw_rst;

  // Gap length candidate; only consumed while in IDLE, so later changes
  // to gap_value or tuser cannot disturb a running countdown.
  assign d = use_reg_gap ? 32'(gap_value) : s_axis_tuser[63:32];

  always_comb begin
    gate = 1'b1;
    if (gap_en) begin
      case (state)
        IDLE:    gate = (d == 32'd0);
        GAP:     gate = (cnt == 32'd0);
        PKT:     gate = 1'b1;
        default: gate = 1'b1;
      endcase
    end
  end

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tstrb  = s_axis_tstrb;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tvalid = s_axis_tvalid & gate & ~rst_any;
  assign s_axis_tready = m_axis_tready & gate & ~rst_any;

  assign xfer = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge axi_aclk) begin
    if (rst_any) begin
      state     <= IDLE;
      cnt       <= 32'd0;
      pkt_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (xfer && s_axis_tlast)
        pkt_cnt <= pkt_cnt + C_S_AXI_DATA_WIDTH'(1);

      if (s_axis_tvalid && !gate && (stall_cnt != '1))
        stall_cnt <= stall_cnt + C_S_AXI_DATA_WIDTH'(1);

      case (state)
        IDLE: begin
          // Loading D-1 makes the gate open exactly D cycles after presentation.
          if (s_axis_tvalid && gap_en && (d != 32'd0)) begin
            cnt   <= d - 32'd1;
            state <= GAP;
          end else if (xfer) begin
            state <= s_axis_tlast ? IDLE : PKT;
          end
        end
        GAP: begin
          // A transfer here is only possible once the gate is open
          // (cnt reached 0 or gap_en was dropped).
          if (xfer)
            state <= s_axis_tlast ? IDLE : PKT;
          else if (cnt != 32'd0)
            cnt <= cnt - 32'd1;
        end
        PKT: begin
          if (xfer && s_axis_tlast)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
